// File: rtl/conv_result_writer_pkg.sv
// Shared definitions for the convolution result writer: FSM states, lane geometry
// and the pixel saturation helper.
package conv_result_writer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  localparam int LANE_WIDTH = 16;
  localparam int EXT_WIDTH  = LANE_WIDTH + 1;
  localparam int PIX_MAX    = 255;

  // Clamp a shifted accumulator into the unsigned 8-bit pixel range.
  function automatic logic [7:0] sat_pix(input logic signed [EXT_WIDTH-1:0] v);
    if (v < 0)            return 8'd0;
    else if (v > PIX_MAX) return 8'd255;
    else                  return v[7:0];
  endfunction

endpackage

// File: rtl/result_fifo.sv
// Small synchronous FIFO; a push into a full FIFO succeeds when a pop happens
// in the same cycle.
module result_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             clear,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr[AW-1:0]];

  // NOTE: storage has no reset; the pointers alone define which entries are valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= din;
  end

  always_ff @(posedge clk) begin
    if (!rstn || clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

endmodule

// File: rtl/conv_result_writer.sv
// Requantizes 8-lane 16-bit results to 8-bit pixels and writes them out through a FIFO.
// Build option: define RESULT_ROUND_EN for round-half-up before the right shift.
module conv_result_writer
  import conv_result_writer_pkg::*;
#(
  parameter int NUM_PE      = 8,
  parameter int PIXEL_WIDTH = 8,
  parameter int ADDR_WIDTH  = 12,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                          clk,
  input  logic                          rstn,
  input  logic                          start,
  input  logic [ADDR_WIDTH-1:0]         dst_base_addr,
  input  logic [3:0]                    shift_amt,
  input  logic                          res_valid,
  input  logic [NUM_PE*LANE_WIDTH-1:0]  res_word,
  input  logic                          frame_done_in,
  output logic                          dst_mem_en,
  output logic                          dst_mem_we,
  output logic [ADDR_WIDTH-1:0]         dst_mem_addr,
  output logic [NUM_PE*PIXEL_WIDTH-1:0] dst_mem_data,
  input  logic                          dst_mem_ready,
  output logic                          busy,
  output logic                          done,
  output logic                          overflow_err,
  output logic [ADDR_WIDTH-1:0]         word_count
);

  localparam int DW = NUM_PE * PIXEL_WIDTH;

  state_e                state_q, state_nx;
  logic [3:0]            shift_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [ADDR_WIDTH-1:0] count_q;
  logic                  s1_valid;
  logic [DW-1:0]         s1_data;
  logic [DW-1:0]         q_word;
  logic [DW-1:0]         last_data;
  logic [DW-1:0]         fifo_head;
  logic                  fifo_full, fifo_empty;
  logic                  fifo_push, fifo_pop;
  logic                  accept, s1_load, drop;
  logic                  overflow_q;

  for (genvar i = 0; i < NUM_PE; i++) begin : g_lane
    logic signed [EXT_WIDTH-1:0] ext;
    logic signed [EXT_WIDTH-1:0] shifted;

    assign ext = $signed({res_word[i*LANE_WIDTH + LANE_WIDTH-1],
                          res_word[i*LANE_WIDTH +: LANE_WIDTH]});
`ifdef RESULT_ROUND_EN
    logic signed [EXT_WIDTH-1:0] bias;
    // The extra bit keeps 32767 + half-LSB from wrapping negative.
    assign bias    = (shift_q == 4'd0) ? '0 : $signed(EXT_WIDTH'(1) << (shift_q - 4'd1));
    assign shifted = (ext + bias) >>> shift_q;
`else
    assign shifted = ext >>> shift_q;
`endif
    assign q_word[i*PIXEL_WIDTH +: PIXEL_WIDTH] = PIXEL_WIDTH'(sat_pix(shifted));
  end

  // Stage 1 holds its word while the FIFO is blocked; a word arriving then is lost.
  assign accept    = res_valid && !start && (state_q == ST_RUN || state_q == ST_FLUSH);
  assign fifo_pop  = !fifo_empty && dst_mem_ready;
  assign fifo_push = s1_valid && (!fifo_full || fifo_pop);
  assign s1_load   = accept && (!s1_valid || fifo_push);
  assign drop      = accept && !s1_load;

  result_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (DW)
  ) u_fifo (
    .clk   (clk),
    .rstn  (rstn),
    .clear (start),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .din   (s1_data),
    .dout  (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q    <= ST_IDLE;
      shift_q    <= '0;
      addr_q     <= '0;
      count_q    <= '0;
      s1_valid   <= 1'b0;
      s1_data    <= '0;
      last_data  <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q <= state_nx;
      if (start) begin
        shift_q    <= shift_amt;
        addr_q     <= dst_base_addr;
        count_q    <= '0;
        s1_valid   <= 1'b0;
        overflow_q <= 1'b0;
      end else begin
        if (fifo_pop) begin
          addr_q    <= addr_q + ADDR_WIDTH'(1);
          count_q   <= count_q + ADDR_WIDTH'(1);
          last_data <= fifo_head;
        end
        if (s1_load) begin
          s1_valid <= 1'b1;
          s1_data  <= q_word;
        end else if (fifo_push) begin
          s1_valid <= 1'b0;
        end
        if (drop) overflow_q <= 1'b1;
      end
    end
  end

  // NOTE: next state gets a default before the case so no path infers a latch.
  always_comb begin
    state_nx = state_q;
    unique case (state_q)
      ST_IDLE:  if (start) state_nx = ST_RUN;
      ST_RUN:   if (frame_done_in) state_nx = ST_FLUSH;
      ST_FLUSH: if (!s1_valid && fifo_empty && !accept) state_nx = ST_DONE;
      ST_DONE:  state_nx = ST_IDLE;
      default:  state_nx = ST_IDLE;
    endcase
    if (start) state_nx = ST_RUN;
  end

  assign dst_mem_en   = !fifo_empty;
  assign dst_mem_we   = !fifo_empty;
  assign dst_mem_addr = addr_q;
  assign dst_mem_data = fifo_empty ? last_data : fifo_head;
  assign busy         = (state_q == ST_RUN) || (state_q == ST_FLUSH);
  assign done         = (state_q == ST_DONE);
  assign overflow_err = overflow_q;
  assign word_count   = count_q;

endmodule

// File: tb/tb_conv_result_writer.sv
// Directed bench for conv_result_writer: quantization vectors plus back-pressure,
// flush, reset and address-wrap sequences.
module tb_conv_result_writer;

  logic         clk = 1'b0;
  logic         rstn;
  logic         start;
  logic [11:0]  dst_base_addr;
  logic [3:0]   shift_amt;
  logic         res_valid;
  logic [127:0] res_word;
  logic         frame_done_in;
  logic         dst_mem_en;
  logic         dst_mem_we;
  logic [11:0]  dst_mem_addr;
  logic [63:0]  dst_mem_data;
  logic         dst_mem_ready;
  logic         busy;
  logic         done;
  logic         overflow_err;
  logic [11:0]  word_count;

  int n_cmp = 0;
  int n_bad = 0;

  conv_result_writer dut (
    .clk           (clk),
    .rstn          (rstn),
    .start         (start),
    .dst_base_addr (dst_base_addr),
    .shift_amt     (shift_amt),
    .res_valid     (res_valid),
    .res_word      (res_word),
    .frame_done_in (frame_done_in),
    .dst_mem_en    (dst_mem_en),
    .dst_mem_we    (dst_mem_we),
    .dst_mem_addr  (dst_mem_addr),
    .dst_mem_data  (dst_mem_data),
    .dst_mem_ready (dst_mem_ready),
    .busy          (busy),
    .done          (done),
    .overflow_err  (overflow_err),
    .word_count    (word_count)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  typedef struct {
    logic [3:0]   shift;
    logic [11:0]  base;
    logic [127:0] word;
    logic [63:0]  exp;
  } vec_t;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [127:0] w16(input int a0, input int a1, input int a2, input int a3,
                                       input int a4, input int a5, input int a6, input int a7);
    return {a7[15:0], a6[15:0], a5[15:0], a4[15:0], a3[15:0], a2[15:0], a1[15:0], a0[15:0]};
  endfunction

  function automatic logic [63:0] p8(input int a0, input int a1, input int a2, input int a3,
                                     input int a4, input int a5, input int a6, input int a7);
    return {a7[7:0], a6[7:0], a5[7:0], a4[7:0], a3[7:0], a2[7:0], a1[7:0], a0[7:0]};
  endfunction

  function automatic logic [127:0] rep16(input int v);
    return {8{v[15:0]}};
  endfunction

  function automatic logic [63:0] rep8(input int v);
    return {8{v[7:0]}};
  endfunction

  task automatic do_start(input logic [11:0] base, input logic [3:0] sh);
    start         = 1'b1;
    dst_base_addr = base;
    shift_amt     = sh;
    tick();
    start         = 1'b0;
  endtask

  vec_t vecs[5];

  initial begin
    int idx;
    int writes;
    logic got_done;

    rstn = 1'b0; start = 1'b0; dst_base_addr = '0; shift_amt = '0;
    res_valid = 1'b0; res_word = '0; frame_done_in = 1'b0; dst_mem_ready = 1'b1;

    vecs[0] = '{4'd0,  12'h100, w16(0, 1, 127, 255, 256, -1, 300, -32768), p8(0, 1, 127, 255, 255, 0, 255, 0)};
`ifdef RESULT_ROUND_EN
    vecs[1] = '{4'd2,  12'h110, w16(4, -4, 1020, 1024, 2, 3, 5, 7),       p8(1, 0, 255, 255, 1, 1, 1, 2)};
    vecs[2] = '{4'd4,  12'h120, w16(4095, 4080, 4079, -16, 100, 32767, 24, 8), p8(255, 255, 255, 0, 6, 255, 2, 1)};
    vecs[3] = '{4'd15, 12'h130, w16(32767, -32768, 16384, 16383, 0, -1, 1, 0), p8(1, 0, 1, 0, 0, 0, 0, 0)};
    vecs[4] = '{4'd8,  12'h140, w16(-1, 32767, 256, 383, 384, 255, 127, 128), p8(0, 128, 1, 1, 2, 1, 0, 1)};
`else
    vecs[1] = '{4'd2,  12'h110, w16(4, -4, 1020, 1024, 2, 3, 5, 7),       p8(1, 0, 255, 255, 0, 0, 1, 1)};
    vecs[2] = '{4'd4,  12'h120, w16(4095, 4080, 4079, -16, 100, 32767, 24, 8), p8(255, 255, 254, 0, 6, 255, 1, 0)};
    vecs[3] = '{4'd15, 12'h130, w16(32767, -32768, 16384, 16383, 0, -1, 1, 0), p8(0, 0, 0, 0, 0, 0, 0, 0)};
    vecs[4] = '{4'd8,  12'h140, w16(-1, 32767, 256, 383, 384, 255, 127, 128), p8(0, 127, 1, 1, 1, 0, 0, 0)};
`endif

    // Reset state
    tick(); tick();
    check("rst_en", dst_mem_en, 0);
    check("rst_addr", dst_mem_addr, 0);
    check("rst_data", dst_mem_data, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_wc", word_count, 0);
    rstn = 1'b1;
    tick();

    // Quantization vectors: valid in cycle N, write visible in N+2
    for (int v = 0; v < 5; v++) begin
      do_start(vecs[v].base, vecs[v].shift);
      check($sformatf("v%0d_busy", v), busy, 1);
      res_valid = 1'b1;
      res_word  = vecs[v].word;
      tick();
      res_valid = 1'b0;
      check($sformatf("v%0d_en_early", v), dst_mem_en, 0);
      tick();
      check($sformatf("v%0d_en", v), dst_mem_en, 1);
      check($sformatf("v%0d_we", v), dst_mem_we, 1);
      check($sformatf("v%0d_addr", v), dst_mem_addr, vecs[v].base);
      check($sformatf("v%0d_data", v), dst_mem_data, vecs[v].exp);
      check($sformatf("v%0d_wc0", v), word_count, 0);
      tick();
      check($sformatf("v%0d_wc1", v), word_count, 1);
      check($sformatf("v%0d_en_after", v), dst_mem_en, 0);
      check($sformatf("v%0d_hold", v), dst_mem_data, vecs[v].exp);
    end

    // Back-pressure: 6 words into a stalled path, one must be dropped
    dst_mem_ready = 1'b0;
    do_start(12'h200, 4'd0);
    check("bp_ovf_cleared", overflow_err, 0);
    for (int k = 0; k < 6; k++) begin
      res_valid = 1'b1;
      res_word  = rep16(10 + k);
      tick();
    end
    res_valid = 1'b0;
    tick(); tick();
    check("bp_ovf", overflow_err, 1);
    check("bp_en", dst_mem_en, 1);
    check("bp_wc", word_count, 0);
    dst_mem_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      check($sformatf("bp_en%0d", k), dst_mem_en, 1);
      check($sformatf("bp_addr%0d", k), dst_mem_addr, 12'h200 + 12'(k));
      check($sformatf("bp_data%0d", k), dst_mem_data, rep8(10 + k));
      tick();
    end
    check("bp_drained", dst_mem_en, 0);
    check("bp_wc5", word_count, 5);
    check("bp_ovf_sticky", overflow_err, 1);

    // Full FIFO with simultaneous pop: no drops
    dst_mem_ready = 1'b0;
    do_start(12'h300, 4'd0);
    check("fp_ovf_cleared", overflow_err, 0);
    for (int k = 0; k < 4; k++) begin
      res_valid = 1'b1;
      res_word  = rep16(20 + k);
      tick();
    end
    res_valid = 1'b0;
    tick();
    dst_mem_ready = 1'b1;
    idx = 0;
    for (int c = 0; c < 30; c++) begin
      res_valid = (c < 6);
      res_word  = rep16(24 + c);
      if (dst_mem_en) begin
        check($sformatf("fp_data%0d", idx), dst_mem_data, rep8(20 + idx));
        idx++;
      end
      tick();
    end
    res_valid = 1'b0;
    check("fp_count", idx, 10);
    check("fp_wc", word_count, 10);
    check("fp_ovf", overflow_err, 0);

    // Flush: frame_done_in coincides with the last valid
    dst_mem_ready = 1'b0;
    do_start(12'h040, 4'd0);
    for (int k = 0; k < 3; k++) begin
      res_valid     = 1'b1;
      res_word      = rep16(30 + k);
      frame_done_in = (k == 2);
      tick();
    end
    res_valid     = 1'b0;
    frame_done_in = 1'b0;
    tick(); tick();
    check("fl_busy", busy, 1);
    check("fl_done_early", done, 0);
    check("fl_en", dst_mem_en, 1);
    dst_mem_ready = 1'b1;
    writes   = 0;
    got_done = 1'b0;
    for (int c = 0; c < 20; c++) begin
      if (done) begin
        got_done = 1'b1;
        break;
      end
      if (dst_mem_en) writes++;
      tick();
    end
    check("fl_done_seen", got_done, 1);
    check("fl_writes", writes, 3);
    check("fl_busy_low", busy, 0);
    check("fl_wc", word_count, 3);
    tick();
    check("fl_done_pulse", done, 0);
    check("fl_idle_busy", busy, 0);

    // Reset mid-frame, then restart with address wrap
    dst_mem_ready = 1'b0;
    do_start(12'h500, 4'd0);
    for (int k = 0; k < 3; k++) begin
      res_valid = 1'b1;
      res_word  = rep16(40 + k);
      tick();
    end
    res_valid = 1'b0;
    tick();
    rstn = 1'b0;
    dst_mem_ready = 1'b1;
    tick();
    check("rr_en", dst_mem_en, 0);
    check("rr_addr", dst_mem_addr, 0);
    check("rr_data", dst_mem_data, 0);
    check("rr_busy", busy, 0);
    check("rr_ovf", overflow_err, 0);
    check("rr_wc", word_count, 0);
    tick();
    check("rr_en2", dst_mem_en, 0);
    rstn = 1'b1;
    tick();
    check("rr_en3", dst_mem_en, 0);
    do_start(12'hFFF, 4'd0);
    res_valid = 1'b1;
    res_word  = rep16(50);
    tick();
    res_word  = rep16(51);
    tick();
    res_valid = 1'b0;
    check("wr_en0", dst_mem_en, 1);
    check("wr_addr0", dst_mem_addr, 12'hFFF);
    check("wr_data0", dst_mem_data, rep8(50));
    tick();
    check("wr_en1", dst_mem_en, 1);
    check("wr_addr1", dst_mem_addr, 12'h000);
    check("wr_data1", dst_mem_data, rep8(51));
    tick();
    check("wr_drained", dst_mem_en, 0);
    check("wr_wc", word_count, 2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
